// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code.
// Holds the default constraint length and generators, the code-pair type,
// the encoder state encoding, and the reference parity function that maps a
// K-bit window {newest, ..., oldest} to a code pair.
package viterbi_pkg;

    localparam int unsigned K  = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef logic [1:0] code_pair_t;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_DATA = 2'd1,
        ENC_TAIL = 2'd2
    } enc_state_t;

    // [1] from G0, [0] from G1; bit K-1 of sr is the newest bit.
    function automatic code_pair_t parity_pair(input logic [K-1:0] sr);
        return {^(G0 & sr), ^(G1 & sr)};
    endfunction

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with zero-tail frame termination.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake for in_bit/in_last
//   in_bit, in_last      data bit and end-of-frame marker
//   out_valid/out_ready  output handshake for code_pair/out_last
//   code_pair            {parity(G0 & sr), parity(G1 & sr)}
//   out_last             final pair of a frame
module conv_encoder #(
    parameter int unsigned              K       = viterbi_pkg::K,
    parameter logic [K-1:0]             G0      = viterbi_pkg::G0,
    parameter logic [K-1:0]             G1      = viterbi_pkg::G1,
    parameter bit                       TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] code_pair,
    output logic       out_last
);
    import viterbi_pkg::*;

    localparam int unsigned HW = K - 1;
    localparam int unsigned CW = (K > 2) ? $clog2(K) : 1;

    enc_state_t   state;
    logic [HW-1:0] hist;
    logic [CW-1:0] tail_cnt;

    logic          free_c;
    logic          accept_c;
    logic          new_bit_c;
    logic [K-1:0]  sr_c;
    logic [HW-1:0] hist_next_c;
    code_pair_t    pair_c;

    // Output register can take a new pair when empty or being drained.
    assign free_c    = !out_valid || out_ready;
    assign in_ready  = rst_n && (state != ENC_TAIL) && free_c;
    assign accept_c  = in_valid && in_ready;

    // Tail cycles feed zeros into the window.
    assign new_bit_c   = (state == ENC_TAIL) ? 1'b0 : in_bit;
    assign sr_c        = {new_bit_c, hist};
    assign hist_next_c = HW'(sr_c >> 1);
    assign pair_c      = {^(G0 & sr_c), ^(G1 & sr_c)};

    // FSM, history shift register and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENC_IDLE;
            hist      <= '0;
            tail_cnt  <= '0;
            out_valid <= 1'b0;
            code_pair <= '0;
            out_last  <= 1'b0;
        end else begin
            if (free_c) begin
                out_valid <= 1'b0;
            end
            case (state)
                ENC_IDLE, ENC_DATA: begin
                    if (accept_c) begin
                        code_pair <= pair_c;
                        out_valid <= 1'b1;
                        state     <= ENC_DATA;
                        if (in_last && TAIL_EN) begin
                            hist     <= hist_next_c;
                            tail_cnt <= CW'(K - 1);
                            out_last <= 1'b0;
                            state    <= ENC_TAIL;
                        end else if (in_last) begin
                            // No tail: close the frame on the data pair itself.
                            hist     <= '0;
                            out_last <= 1'b1;
                        end else begin
                            hist     <= hist_next_c;
                            out_last <= 1'b0;
                        end
                    end
                end
                ENC_TAIL: begin
                    if (free_c) begin
                        code_pair <= pair_c;
                        out_valid <= 1'b1;
                        hist      <= hist_next_c;
                        tail_cnt  <= tail_cnt - CW'(1);
                        if (tail_cnt == CW'(1)) begin
                            out_last <= 1'b1;
                            state    <= ENC_DATA;
                        end else begin
                            out_last <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ENC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: a tailed instance (u_dut) and an untailed
// instance (u_dut_nt). Emitted pairs are collected as {out_last, code_pair}
// and compared against hand-computed sequences.
module tb_conv_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, in_bit, in_last;
    logic       out_valid, out_ready, out_last;
    logic [1:0] code_pair;

    logic       z_in_valid, z_in_ready, z_in_bit, z_in_last;
    logic       z_out_valid, z_out_ready, z_out_last;
    logic [1:0] z_code_pair;

    int checks = 0;
    int errors = 0;

    logic [2:0] got  [$];
    logic [2:0] gotz [$];
    logic [2:0] exp_q[$];

    logic       tog = 1'b0;
    logic [3:0] pat = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 0 first)
    int         cyc = 0;

    logic       prev_stall = 1'b0;
    logic [1:0] prev_code  = '0;
    logic       prev_last  = 1'b0;

    conv_encoder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_pair (code_pair),
        .out_last  (out_last)
    );

    conv_encoder #(.TAIL_EN(1'b0)) u_dut_nt (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (z_in_valid),
        .in_ready  (z_in_ready),
        .in_bit    (z_in_bit),
        .in_last   (z_in_last),
        .out_valid (z_out_valid),
        .out_ready (z_out_ready),
        .code_pair (z_code_pair),
        .out_last  (z_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every transferred pair.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back({out_last, code_pair});
        if (rst_n && z_out_valid && z_out_ready) gotz.push_back({z_out_last, z_code_pair});
    end

    // A stalled pair must be held unchanged until it is taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                assert (out_valid === 1'b1 && code_pair === prev_code && out_last === prev_last)
                else begin
                    errors++;
                    $error("FAIL stall_hold observed=%0b/%0b/%0b expected=1/%0b/%0b",
                           out_valid, code_pair, out_last, prev_code, prev_last);
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_code  <= code_pair;
            prev_last  <= out_last;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge, sampled 2 after.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (tog) out_ready = pat[cyc % 4];
        cyc++;
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] bits, input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            if (sel) begin
                z_in_valid = 1'b1; z_in_bit = bits[i]; z_in_last = (i == n - 1);
            end else begin
                in_valid = 1'b1; in_bit = bits[i]; in_last = (i == n - 1);
            end
            #0;
            acc = 1'b0;
            for (int k = 0; k < 100 && !acc; k++) begin
                acc = sel ? z_in_ready : in_ready;
                cycle();
            end
            chk("accept_timeout", 8'(acc), 8'd1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        z_in_valid = 1'b0; z_in_last = 1'b0;
    endtask

    // Wait (bounded) for the expected number of pairs, then compare them.
    task automatic compare(input bit sel, input string tag);
        for (int k = 0; k < 200 && ((sel ? gotz.size() : got.size()) < exp_q.size()); k++) cycle();
        chk({tag, "_count"}, 8'(sel ? gotz.size() : got.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < (sel ? gotz.size() : got.size()))
                chk($sformatf("%s_pair%0d", tag, i), 8'(sel ? gotz[i] : got[i]), 8'(exp_q[i]));
        end
        got.delete();
        gotz.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        z_in_valid = 1'b0; z_in_bit = 1'b0; z_in_last = 1'b0; z_out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 8'(in_ready), 8'd0);
        cycle(); cycle();
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_code_pair", 8'(code_pair), 8'd0);
        chk("rst_out_last", 8'(out_last), 8'd0);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_in_ready", 8'(in_ready), 8'd1);

        // Frame 1,0,1,1 at full throughput.
        send_frame(1'b0, 8'b0000_1101, 4);
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        compare(1'b0, "frame_1011");

        // Same frame under out_ready 1,0,0,1,... backpressure.
        tog = 1'b1; cyc = 0;
        send_frame(1'b0, 8'b0000_1101, 4);
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        compare(1'b0, "frame_1011_bp");
        tog = 1'b0; out_ready = 1'b1;
        cycle();

        // Back-to-back single-bit frames.
        send_frame(1'b0, 8'b0000_0001, 1);
        send_frame(1'b0, 8'b0000_0001, 1);
        exp_q = '{3'b011, 3'b010, 3'b111, 3'b011, 3'b010, 3'b111};
        compare(1'b0, "b2b");

        // Next frame held off during the tail, then encoded from state 0.
        send_frame(1'b0, 8'b0000_0001, 1);
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
        #0;
        chk("tail_hold0", 8'(in_ready), 8'd0);
        cycle();
        chk("tail_hold1", 8'(in_ready), 8'd0);
        cycle();
        chk("tail_release", 8'(in_ready), 8'd1);
        cycle();
        in_valid = 1'b0; in_last = 1'b0;
        exp_q = '{3'b011, 3'b010, 3'b111, 3'b011, 3'b010, 3'b111};
        compare(1'b0, "held_off");

        // Reset in the middle of a tail.
        send_frame(1'b0, 8'b0000_0001, 1);
        chk("pre_rst_out_valid", 8'(out_valid), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("midtail_out_valid", 8'(out_valid), 8'd0);
        chk("midtail_in_ready", 8'(in_ready), 8'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        got.delete(); gotz.delete();
        send_frame(1'b0, 8'b0000_0001, 2);
        exp_q = '{3'b011, 3'b010, 3'b011, 3'b100};
        compare(1'b0, "after_rst");

        // Untailed instance: frame 1,1 then frame 1.
        send_frame(1'b1, 8'b0000_0011, 2);
        exp_q = '{3'b011, 3'b101};
        compare(1'b1, "notail_11");
        send_frame(1'b1, 8'b0000_0001, 1);
        exp_q = '{3'b111};
        compare(1'b1, "notail_1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
